// File: rtl/bouncing_sprite_gen.sv
// Bouncing-rectangle video source: moves a sprite inside a padded window, paced by frame ticks.
// Optional saturating bounce counter enabled by defining BOUNCE_COUNT_EN.
module bouncing_sprite_gen #(
   parameter int H_VIS    = 640,
   parameter int V_VIS    = 480,
   parameter int PAD      = 50,
   parameter int SPR_W    = 85,
   parameter int SPR_H    = 50,
   parameter int STEP_X   = 4,
   parameter int STEP_Y   = 3,
   parameter int DIV      = 1,
   parameter int X0       = 100,
   parameter int Y0       = 100,
   parameter int FLASH_FR = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       pause,
   input  logic       video_active,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   output logic [5:0] rgb,
   output logic       bounce,
   output logic       corner_hit,
   output logic [7:0] bounce_cnt
);

   localparam logic [9:0]  X_MIN    = 10'(PAD);
   localparam logic [9:0]  X_MAX    = 10'(H_VIS - PAD - SPR_W);
   localparam logic [9:0]  Y_MIN    = 10'(PAD);
   localparam logic [9:0]  Y_MAX    = 10'(V_VIS - PAD - SPR_H);
   localparam logic [10:0] SX       = 11'(STEP_X);
   localparam logic [10:0] SY       = 11'(STEP_Y);
   localparam logic [10:0] SW       = 11'(SPR_W);
   localparam logic [10:0] SH       = 11'(SPR_H);
   localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);
   localparam logic [7:0]  FLASH_LD = 8'(FLASH_FR);
   localparam logic [5:0]  BG_FLASH = 6'b010101;

   if (!(SPR_W < H_VIS - 2*PAD) || !(SPR_H < V_VIS - 2*PAD)) begin : g_size_check
      $error("bouncing_sprite_gen: sprite does not fit inside the padded window");
   end

   function automatic logic [5:0] pal_color(input logic [1:0] idx);
      logic [5:0] c;
      case (idx)
         2'd0:    c = 6'b111111;
         2'd1:    c = 6'b110000;
         2'd2:    c = 6'b001100;
         2'd3:    c = 6'b000011;
         default: c = 6'b000000;
      endcase
      return c;
   endfunction

   // One axis step: result is {hit, new_dir_fwd, new_pos}; left underflow is caught before the wrap.
   function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic fwd,
                                             input logic [10:0] step,
                                             input logic [9:0] lo, input logic [9:0] hi);
      logic [10:0] np;
      logic [11:0] r;
      np = fwd ? ({1'b0, pos} + step) : ({1'b0, pos} - step);
      if (fwd && (np > {1'b0, hi})) begin
         r = {1'b1, 1'b0, hi};
      end else if (!fwd && (({1'b0, pos} < step) || (np < {1'b0, lo}))) begin
         r = {1'b1, 1'b1, lo};
      end else begin
         r = {1'b0, fwd, np[9:0]};
      end
      return r;
   endfunction

   logic [9:0]  x_q, x_d, y_q, y_d;
   logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic [1:0]  pal_q, pal_d;
   logic [7:0]  div_q, div_d;
   logic [7:0]  flash_q, flash_d;
   logic [5:0]  rgb_q, rgb_d;
   logic        bounce_q, bounce_d, corner_q, corner_d;
   logic        tick_s, upd_s, hit_any_s, in_spr_s;
   logic [11:0] ax_s, ay_s;

   // Next-state: divider, motion, palette, flash timer and the pixel colour.
   always_comb begin
      tick_s    = frame_tick && !pause;
      upd_s     = tick_s && (div_q == DIV_LAST);
      ax_s      = axis_step(x_q, dir_x_q, SX, X_MIN, X_MAX);
      ay_s      = axis_step(y_q, dir_y_q, SY, Y_MIN, Y_MAX);
      hit_any_s = upd_s && (ax_s[11] || ay_s[11]);
      bounce_d  = hit_any_s;
      corner_d  = upd_s && ax_s[11] && ay_s[11];

      if (tick_s) begin
         div_d = (div_q == DIV_LAST) ? 8'd0 : (div_q + 8'd1);
      end else begin
         div_d = div_q;
      end

      if (upd_s) begin
         x_d     = ax_s[9:0];
         dir_x_d = ax_s[10];
         y_d     = ay_s[9:0];
         dir_y_d = ay_s[10];
      end else begin
         x_d     = x_q;
         dir_x_d = dir_x_q;
         y_d     = y_q;
         dir_y_d = dir_y_q;
      end

      pal_d = hit_any_s ? (pal_q + 2'd1) : pal_q;

      // A fresh bounce reloads the timer; otherwise it counts frames down even while paused.
      if (hit_any_s) begin
         flash_d = FLASH_LD;
      end else if (frame_tick && (flash_q != 8'd0)) begin
         flash_d = flash_q - 8'd1;
      end else begin
         flash_d = flash_q;
      end

      in_spr_s = ({1'b0, pix_x} >= {1'b0, x_q}) && ({1'b0, pix_x} < ({1'b0, x_q} + SW)) &&
                 ({1'b0, pix_y} >= {1'b0, y_q}) && ({1'b0, pix_y} < ({1'b0, y_q} + SH));

      if (!video_active) begin
         rgb_d = 6'b000000;
      end else if (in_spr_s) begin
         rgb_d = pal_color(pal_q);
      end else if (flash_q != 8'd0) begin
         rgb_d = BG_FLASH;
      end else begin
         rgb_d = 6'b000000;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q      <= 10'(X0);
         y_q      <= 10'(Y0);
         dir_x_q  <= 1'b1;
         dir_y_q  <= 1'b1;
         pal_q    <= 2'd0;
         div_q    <= 8'd0;
         flash_q  <= 8'd0;
         rgb_q    <= 6'd0;
         bounce_q <= 1'b0;
         corner_q <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         pal_q    <= pal_d;
         div_q    <= div_d;
         flash_q  <= flash_d;
         rgb_q    <= rgb_d;
         bounce_q <= bounce_d;
         corner_q <= corner_d;
      end
   end

   assign rgb        = rgb_q;
   assign bounce     = bounce_q;
   assign corner_hit = corner_q;

`ifdef BOUNCE_COUNT_EN
   logic [7:0] bcnt_q, bcnt_d;

   // Saturating count; a corner produces a single bounce so it counts once.
   always_comb begin
      if (hit_any_s && (bcnt_q != 8'hFF)) begin
         bcnt_d = bcnt_q + 8'd1;
      end else begin
         bcnt_d = bcnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q <= 8'd0;
      end else begin
         bcnt_q <= bcnt_d;
      end
   end

   assign bounce_cnt = bcnt_q;
`else
   assign bounce_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_bouncing_sprite_gen.sv
// Randomized bench for bouncing_sprite_gen: two instances (default and divided/corner setups)
// checked against a rule-level model of sprite motion, palette, flash and pixel colour.
module tb_bouncing_sprite_gen;

   logic       clk = 1'b0;
   logic       rst_n, frame_tick, pause, video_active;
   logic [9:0] pix_x, pix_y;
   logic [5:0] rgb_a, rgb_b;
   logic       bounce_a, bounce_b, corner_a, corner_b;
   logic [7:0] bcnt_a, bcnt_b;

   always #5 clk = ~clk;

   bouncing_sprite_gen dut_a (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
      .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y),
      .rgb(rgb_a), .bounce(bounce_a), .corner_hit(corner_a), .bounce_cnt(bcnt_a));

   bouncing_sprite_gen #(.STEP_X(4), .STEP_Y(4), .DIV(3), .X0(501), .Y0(376), .FLASH_FR(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
      .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y),
      .rgb(rgb_b), .bounce(bounce_b), .corner_hit(corner_b), .bounce_cnt(bcnt_b));

   // Per-instance configuration, index 0 = dut_a, 1 = dut_b
   int P_X0[2] = '{100, 501};
   int P_Y0[2] = '{100, 376};
   int P_SX[2] = '{4, 4};
   int P_SY[2] = '{3, 4};
   int P_DV[2] = '{1, 3};
   int P_FL[2] = '{8, 3};
   localparam int HV = 640, VV = 480, PD = 50, W = 85, H = 50;
   logic [5:0] PAL[4] = '{6'b111111, 6'b110000, 6'b001100, 6'b000011};

   int m_x[2], m_y[2], m_dx[2], m_dy[2], m_pal[2], m_div[2], m_flash[2], m_bcnt[2];
   bit m_b[2], m_c[2];
   int n_checks = 0;
   int n_fail = 0;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_x[i] = P_X0[i]; m_y[i] = P_Y0[i]; m_dx[i] = 1; m_dy[i] = 1;
         m_pal[i] = 0; m_div[i] = 0; m_flash[i] = 0; m_bcnt[i] = 0;
         m_b[i] = 0; m_c[i] = 0;
      end
   endtask

   task automatic axis(inout int pos, inout int dir, input int step, input int vis,
                       input int size, output bit hit);
      int np;
      np  = pos + dir * step;
      hit = 1'b1;
      if (np + size > vis - PD) begin
         pos = vis - PD - size; dir = -1;
      end else if (np < PD) begin
         pos = PD; dir = 1;
      end else begin
         pos = np; hit = 1'b0;
      end
   endtask

   task automatic model_tick(input bit p);
      for (int i = 0; i < 2; i++) begin
         bit bx, by;
         m_b[i] = 0; m_c[i] = 0;
         if (m_flash[i] > 0) m_flash[i]--;
         if (!p) begin
            m_div[i]++;
            if (m_div[i] == P_DV[i]) begin
               m_div[i] = 0;
               axis(m_x[i], m_dx[i], P_SX[i], HV, W, bx);
               axis(m_y[i], m_dy[i], P_SY[i], VV, H, by);
               if (bx || by) begin
                  m_b[i] = 1; m_c[i] = bx && by;
                  m_pal[i] = (m_pal[i] + 1) % 4;
                  m_flash[i] = P_FL[i];
                  if (m_bcnt[i] < 255) m_bcnt[i]++;
               end
            end
         end
      end
   endtask

   function automatic logic [5:0] exp_rgb(int i, int px, int py, bit va);
      if (!va) return 6'b000000;
      if (px >= m_x[i] && px < m_x[i] + W && py >= m_y[i] && py < m_y[i] + H) return PAL[m_pal[i]];
      if (m_flash[i] != 0) return 6'b010101;
      return 6'b000000;
   endfunction

   function automatic logic [7:0] exp_bcnt(int i);
`ifdef BOUNCE_COUNT_EN
      return 8'(m_bcnt[i]);
`else
      return 8'd0;
`endif
   endfunction

   task automatic tick(input bit p);
      @(negedge clk); frame_tick = 1'b1; pause = p;
      @(negedge clk); frame_tick = 1'b0; pause = 1'b0;
      model_tick(p);
   endtask

   task automatic drive_pix(input int px, input int py, input bit va);
      @(negedge clk); pix_x = 10'(px); pix_y = 10'(py); video_active = va;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_tick = 1'b0; pause = 1'b0; video_active = 1'b0; pix_x = '0; pix_y = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rgb_a, bounce_a, corner_a, bcnt_a, rgb_b, bounce_b, corner_b, bcnt_b} !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got a=%b/%b/%b/%0d b=%b/%b/%b/%0d expected all zero",
                  rgb_a, bounce_a, corner_a, bcnt_a, rgb_b, bounce_b, corner_b, bcnt_b);
      end
      rst_n = 1'b1;
      model_reset();
      // Pixel probes around dut_a's reset position
      for (int k = 0; k < 4; k++) begin
         int px, py; bit va;
         px = (k == 1) ? 185 : ((k == 2) ? 184 : 100);
         py = (k == 2) ? 149 : 100;
         va = (k != 3);
         drive_pix(px, py, va);
         n_checks++;
         if (rgb_a !== exp_rgb(0, px, py, va) || rgb_b !== exp_rgb(1, px, py, va)) begin
            n_fail++;
            $display("FAIL reset_pixel (%0d,%0d,va=%0d) got a=%b b=%b expected a=%b b=%b",
                     px, py, va, rgb_a, rgb_b, exp_rgb(0, px, py, va), exp_rgb(1, px, py, va));
         end
      end
   endtask

   task automatic test_pause_div();
      do_reset();
      for (int t = 1; t <= 11; t++) begin
         tick(t >= 2 && t <= 5);
         n_checks++;
         if (bounce_b !== m_b[1] || corner_b !== m_c[1] || bcnt_b !== exp_bcnt(1)) begin
            n_fail++;
            $display("FAIL pause_div tick %0d got b/c/cnt=%b/%b/%0d expected %b/%b/%0d",
                     t, bounce_b, corner_b, bcnt_b, m_b[1], m_c[1], exp_bcnt(1));
         end
      end
      drive_pix(m_x[1], m_y[1], 1'b1);
      n_checks++;
      if (rgb_b !== exp_rgb(1, m_x[1], m_y[1], 1'b1)) begin
         n_fail++;
         $display("FAIL pause_div_pixel got %b expected %b", rgb_b, exp_rgb(1, m_x[1], m_y[1], 1'b1));
      end
   endtask

   task automatic test_motion_random();
      for (int it = 0; it < 260; it++) begin
         bit p, any;
         p = ($urandom_range(0, 4) == 0);
         tick(p);
         n_checks++;
         if (bounce_a !== m_b[0] || corner_a !== m_c[0] || bcnt_a !== exp_bcnt(0) ||
             bounce_b !== m_b[1] || corner_b !== m_c[1] || bcnt_b !== exp_bcnt(1)) begin
            n_fail++;
            $display("FAIL motion_flags iter %0d got a=%b/%b/%0d b=%b/%b/%0d expected a=%b/%b/%0d b=%b/%b/%0d",
                     it, bounce_a, corner_a, bcnt_a, bounce_b, corner_b, bcnt_b,
                     m_b[0], m_c[0], exp_bcnt(0), m_b[1], m_c[1], exp_bcnt(1));
         end
         any = m_b[0] || m_b[1];
         if (any) begin
            @(negedge clk);
            n_checks++;
            if (bounce_a !== 1'b0 || bounce_b !== 1'b0 || corner_a !== 1'b0 || corner_b !== 1'b0) begin
               n_fail++;
               $display("FAIL bounce_width iter %0d got a=%b/%b b=%b/%b expected zeros",
                        it, bounce_a, corner_a, bounce_b, corner_b);
            end
         end
         for (int k = 0; k < 2; k++) begin
            int i, px, py; bit va;
            i  = $urandom_range(0, 1);
            px = m_x[i] + (($urandom_range(0, 1) == 1) ? W - 1 : 0) + ($urandom_range(0, 1) == 1 ? 1 : 0) - ($urandom_range(0, 3) == 0 ? 1 : 0);
            py = m_y[i] + (($urandom_range(0, 1) == 1) ? H - 1 : 0) + ($urandom_range(0, 1) == 1 ? 1 : 0) - ($urandom_range(0, 3) == 0 ? 1 : 0);
            va = ($urandom_range(0, 7) != 0);
            drive_pix(px, py, va);
            n_checks++;
            if (rgb_a !== exp_rgb(0, px, py, va) || rgb_b !== exp_rgb(1, px, py, va)) begin
               n_fail++;
               $display("FAIL motion_pixel iter %0d (%0d,%0d,va=%0d) got a=%b b=%b expected a=%b b=%b",
                        it, px, py, va, rgb_a, rgb_b, exp_rgb(0, px, py, va), exp_rgb(1, px, py, va));
            end
         end
      end
   endtask

   task automatic test_flash_reset();
      int guard;
      guard = 0;
      do_reset();
      while (m_flash[0] == 0 && guard < 300) begin
         tick(1'b0);
         guard++;
      end
      n_checks++;
      if (m_flash[0] == 0 || bounce_a !== 1'b1) begin
         n_fail++;
         $display("FAIL flash_bounce_timeout got bounce=%b after %0d ticks expected bounce=1", bounce_a, guard);
      end
      for (int t = 0; t < 3; t++) begin
         tick(t == 1);
         drive_pix(0, 0, 1'b1);
         n_checks++;
         if (rgb_a !== exp_rgb(0, 0, 0, 1'b1) || rgb_b !== exp_rgb(1, 0, 0, 1'b1)) begin
            n_fail++;
            $display("FAIL flash_bg step %0d got a=%b b=%b expected a=%b b=%b",
                     t, rgb_a, rgb_b, exp_rgb(0, 0, 0, 1'b1), exp_rgb(1, 0, 0, 1'b1));
         end
      end
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (rgb_a !== 6'd0 || rgb_b !== 6'd0 || bcnt_a !== 8'd0 || bcnt_b !== 8'd0) begin
         n_fail++;
         $display("FAIL async_reset got rgb a=%b b=%b cnt a=%0d b=%0d expected zeros", rgb_a, rgb_b, bcnt_a, bcnt_b);
      end
      @(negedge clk); rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (rgb_a !== exp_rgb(0, 0, 0, 1'b1) || rgb_b !== exp_rgb(1, 0, 0, 1'b1)) begin
         n_fail++;
         $display("FAIL post_reset_bg got a=%b b=%b expected a=%b b=%b",
                  rgb_a, rgb_b, exp_rgb(0, 0, 0, 1'b1), exp_rgb(1, 0, 0, 1'b1));
      end
   endtask

   initial begin
      test_reset();
      test_pause_div();
      do_reset();
      test_motion_random();
      test_flash_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
